// File: rtl/mac_feeder.sv
// mac_feeder: buffers unsigned 8-bit operand pairs in a small FIFO and feeds
// them, one pair per cycle, to an external multiply-accumulate unit. Each
// vector (terminated by a pair flagged last) is summed by the MAC; the
// finished accumulator value is captured and offered downstream.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand pair handshake (in_a, in_b, in_last)
//   mac_a, mac_b        registered operands to the MAC
//   mac_clr             MAC clear, high while the feeder is in CLEAR
//   acc                 MAC accumulator value
//   res_valid/res_ready result handshake carrying res_data
module mac_feeder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  mac_a,
    output logic [7:0]  mac_b,
    output logic        mac_clr,
    input  logic [15:0] acc,
    output logic        res_valid,
    output logic [15:0] res_data,
    input  logic        res_ready
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        RUN     = 2'd1,
        FLUSH   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    // Entry layout: {a, b, last}
    logic [16:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [16:0] head;

    logic        capture;
    logic [7:0]  a_nx;
    logic [7:0]  b_nx;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign in_ready = !full;
    assign push  = in_valid && !full;
    assign head  = mem[rptr[AW-1:0]];

    // Storage has no reset; pointers alone define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= {in_a, in_b, in_last};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            CLEAR:   state_nx = RUN;
            RUN:     if (!empty && head[0]) state_nx = FLUSH;
            FLUSH:   state_nx = CAPTURE;
            CAPTURE: if (capture) state_nx = CLEAR;
        endcase
    end

    // Output decode: operands are zero except on a pop in RUN
    always_comb begin
        pop     = (state == RUN) && !empty;
        capture = (state == CAPTURE) && (!res_valid || res_ready);
        a_nx    = pop ? head[16:9] : 8'd0;
        b_nx    = pop ? head[8:1]  : 8'd0;
    end

    assign mac_clr = (state == CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_a <= 8'd0;
            mac_b <= 8'd0;
        end else begin
            mac_a <= a_nx;
            mac_b <= b_nx;
        end
    end

    // A capture on the same edge as a handshake keeps res_valid high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= 16'd0;
        end else begin
            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= acc;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter DEPTH, default 4: operand FIFO entries (power of two, >=2).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream offers an operand pair.
REQ-005 in_a  input  8  unsigned multiplicand.
REQ-006 in_b  input  8  unsigned multiplier.
REQ-007 in_last  input  1  pair is the final term of the current vector.
REQ-008 in_ready  output  1  FIFO can accept a pair this cycle.
REQ-009 mac_a  output  8  registered operand to MAC port a.
REQ-010 mac_b  output  8  registered operand to MAC port b.
REQ-011 mac_clr  output  1  clear to MAC rst, high for exactly the CLEAR state.
REQ-012 acc  input  16  MAC accumulator (acc <= acc + a*b each edge; cleared by rst).
REQ-013 res_valid  output  1  res_data holds a completed dot product.
REQ-014 res_data  output  16  captured accumulator value.
REQ-015 res_ready  input  1  downstream accepts res_data.

Function
REQ-016 Push occurs when in_valid && in_ready; in_ready SHALL equal !full; a push into a full FIFO SHALL be impossible.
REQ-017 FIFO SHALL store {in_a, in_b, in_last}, pop only in RUN, with no bypass: a pair pushed in cycle n pops no earlier than the edge ending cycle n+1.
REQ-018 Simultaneous push and pop on a non-empty, non-full FIFO SHALL keep occupancy unchanged; pointers wrap modulo DEPTH.
REQ-019 FSM states: CLEAR, RUN, FLUSH, CAPTURE; mac_clr SHALL be a decode of state==CLEAR.
REQ-020 CLEAR: mac_a=mac_b=0; next state RUN unconditionally (one cycle).
REQ-021 RUN, FIFO empty: mac_a/mac_b <= 0, stay RUN.
REQ-022 RUN, FIFO non-empty: pop; mac_a/mac_b <= popped pair; next state FLUSH if popped in_last, else RUN.
REQ-023 FLUSH: mac_a/mac_b <= 0; next state CAPTURE (last pair on mac_a/mac_b is summed by MAC this cycle).
REQ-024 CAPTURE: if !res_valid || res_ready, res_data <= acc, res_valid <= 1, next CLEAR; otherwise hold CAPTURE with zero operands (acc stable).
REQ-025 Latency: last pair on mac_a/mac_b in cycle T -> res_valid=1 in T+2, mac_clr=1 in T+2, next vector's first pair on mac_a no earlier than T+4.
REQ-026 res_valid SHALL clear on res_valid && res_ready unless a new capture occurs that same edge (capture wins, res_valid stays 1).
REQ-027 res_data SHALL not change while res_valid && !res_ready.
REQ-028 Arithmetic: operands unsigned 8-bit; res_data is acc unmodified, 16 bits; MAC wrap beyond 16 bits is not detected.
REQ-029 Pushes SHALL continue in any state while the FIFO is not full.

Reset
REQ-030 While rst=1: FIFO empty, in_ready=1, state=CLEAR, mac_clr=1, mac_a=mac_b=0, res_valid=0, res_data=0.
REQ-031 After rst falls, CLEAR SHALL persist for one more cycle before RUN.
REQ-032 Reset asserted mid-vector SHALL discard FIFO contents, the partial vector, and any pending result.

Verification
REQ-033 Reset mid-stream with 2 pairs queued -> immediately mac_clr=1, res_valid=0, in_ready=1, mac_a=0; queued pairs never appear on mac_a.
REQ-034 Pairs (5,1),(5,2),(5,3,last), res_ready=1 -> res_data=30, res_valid in T+2 after (5,3) on mac_a, one-cycle mac_clr pulse in T+2.
REQ-035 Back-to-back (5,1),(5,2),(5,3,last),(4,1),(4,2),(4,3,last) -> results 30 then 24, mac_clr pulse between vectors, no term lost.
REQ-036 res_ready=0 through both vectors of REQ-035 -> FSM holds CAPTURE, res_data stays 30; raise res_ready -> 30 accepted, then 24 captured next edge.
REQ-037 During CAPTURE stall push 6 pairs -> in_ready=0 after 4 accepted, 5th held until a pop; occupancy never exceeds 4.
REQ-038 Single-term vector (255,255,last) -> res_data=65025 (0xFE01).
